// File: rtl/map_ss_pkg.sv
`default_nettype none
// ============================================================================
// Module : map_ss_pkg
// Brief  : Shared types and constants for the mapper save-state engine.
// Rev    : 1.0  initial release
// ============================================================================
package map_ss_pkg;

    localparam int SS_IDX_ADDR   = 127;
    localparam int SS_REG_CNT    = 127;
    localparam int SS_STREAM_LEN = SS_REG_CNT + 1;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_S_ADDR  = 4'd1,
        ST_S_WAIT  = 4'd2,
        ST_S_PUSH  = 4'd3,
        ST_L_IDX   = 4'd4,
        ST_L_HDR   = 4'd5,
        ST_L_PULL  = 4'd6,
        ST_L_WRITE = 4'd7,
        ST_DONE    = 4'd8
    } eng_state_t;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_SETUP = 2'd1,
        SB_STRB  = 2'd2,
        SB_HOLD  = 2'd3
    } strb_state_t;

    function automatic int stream_len(input int reg_cnt);
        return reg_cnt + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/map_ss_if.sv
`default_nettype none
// ============================================================================
// Module : map_ss_if
// Brief  : Save-state port between the engine (master) and a mapper (slave).
// Rev    : 1.0  initial release
// ============================================================================
interface map_ss_if;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic       ss_m2;
    logic [7:0] ss_rdat;

    modport master (output ss_act, ss_we, ss_addr, ss_wdat, ss_m2, input ss_rdat);
    modport slave  (input ss_act, ss_we, ss_addr, ss_wdat, ss_m2, output ss_rdat);
endinterface
`default_nettype wire

// File: rtl/map_ss_strobe.sv
`default_nettype none
// ============================================================================
// Module : map_ss_strobe
// Brief  : Setup / m2-low pulse / hold sequencer for one save-state write.
// Rev    : 1.0  initial release
// ============================================================================
module map_ss_strobe
    import map_ss_pkg::*;
#(
    parameter int WR_SETUP = 2,
    parameter int WR_PULSE = 4
) (
    input  wire  clk,
    input  wire  sys_rst_n,
    input  wire  i_start,
    output logic o_done,
    output logic o_ss_we,
    output logic o_ss_m2
);
    localparam logic [3:0] c_setup_last = 4'(WR_SETUP - 1);
    localparam logic [3:0] c_pulse_last = 4'(WR_PULSE - 1);

    strb_state_t r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_we, r_m2;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 4'd1;
        case (r_state)
            SB_IDLE: begin
                w_cnt_nxt = '0;
                if (i_start) w_state_nxt = SB_SETUP;
            end
            SB_SETUP: if (r_cnt == c_setup_last) begin
                w_state_nxt = SB_STRB;
                w_cnt_nxt   = '0;
            end
            SB_STRB: if (r_cnt == c_pulse_last) begin
                w_state_nxt = SB_HOLD;
                w_cnt_nxt   = '0;
            end
            SB_HOLD: begin
                w_state_nxt = SB_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = SB_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Strobe outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= SB_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_m2    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= (w_state_nxt != SB_IDLE);
            r_m2    <= (w_state_nxt != SB_STRB);
        end
    end

    assign o_done  = (r_state == SB_HOLD);
    assign o_ss_we = r_we;
    assign o_ss_m2 = r_m2;
endmodule
`default_nettype wire

// File: rtl/map_ss_engine.sv
`default_nettype none
// ============================================================================
// Module : map_ss_engine
// Brief  : Save-state initiator; streams a mapper register image out (SAVE) or in (LOAD).
// Rev    : 1.0  initial release
// ============================================================================
module map_ss_engine
    import map_ss_pkg::*;
#(
    parameter int REG_CNT  = SS_REG_CNT,
    parameter int IDX_ADDR = SS_IDX_ADDR,
    parameter int RD_WAIT  = 2,
    parameter int WR_SETUP = 2,
    parameter int WR_PULSE = 4
) (
    input  wire        clk,
    input  wire        sys_rst_n,
    input  wire        cmd_save,
    input  wire        cmd_load,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] so_dat,
    output logic       so_valid,
    input  wire        so_ready,
    input  wire  [7:0] si_dat,
    input  wire        si_valid,
    output logic       si_ready,
    map_ss_if.master   ss
);
    localparam logic [7:0] c_idx_addr  = 8'(IDX_ADDR);
    localparam logic [7:0] c_last_addr = 8'(REG_CNT - 1);
    localparam logic [3:0] c_rd_last   = 4'(RD_WAIT - 1);

    eng_state_t r_state, w_state_nxt;
    logic [7:0] r_addr, w_addr_nxt;
    logic [3:0] r_wcnt, w_wcnt_nxt;
    logic       r_hdr, w_hdr_nxt;
    logic [7:0] r_idx, w_idx_nxt;
    logic [7:0] r_so_dat, w_so_dat_nxt;
    logic [7:0] r_wdat, w_wdat_nxt;
    logic       r_err, w_err_nxt;
    logic       r_act, r_done, r_so_valid, r_si_ready;
    logic       w_strb_start, w_strb_done, w_we, w_m2;

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_wcnt_nxt   = r_wcnt;
        w_hdr_nxt    = r_hdr;
        w_idx_nxt    = r_idx;
        w_so_dat_nxt = r_so_dat;
        w_wdat_nxt   = r_wdat;
        w_err_nxt    = r_err;
        w_strb_start = 1'b0;
        case (r_state)
            ST_IDLE: if (cmd_save || cmd_load) begin
                w_err_nxt  = 1'b0;
                w_wcnt_nxt = '0;
                w_hdr_nxt  = 1'b1;
                if (cmd_save && cmd_load) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_addr_nxt  = c_idx_addr;
                    w_state_nxt = cmd_save ? ST_S_ADDR : ST_L_IDX;
                end
            end
            ST_S_ADDR: begin
                w_wcnt_nxt  = '0;
                w_state_nxt = ST_S_WAIT;
            end
            ST_S_WAIT: begin
                w_wcnt_nxt = r_wcnt + 4'd1;
                if (r_wcnt == c_rd_last) begin
                    w_so_dat_nxt = ss.ss_rdat;
                    w_state_nxt  = ST_S_PUSH;
                end
            end
            ST_S_PUSH: if (so_ready) begin
                w_hdr_nxt = 1'b0;
                if (!r_hdr && r_addr == c_last_addr) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    // After the header the index restarts at register 0, never IDX_ADDR+1.
                    w_addr_nxt  = r_hdr ? 8'd0 : r_addr + 8'd1;
                    w_state_nxt = ST_S_ADDR;
                end
            end
            ST_L_IDX: begin
                w_wcnt_nxt = r_wcnt + 4'd1;
                if (r_wcnt == c_rd_last) begin
                    w_idx_nxt   = ss.ss_rdat;
                    w_state_nxt = ST_L_HDR;
                end
            end
            ST_L_HDR: if (si_valid) begin
                if (si_dat != r_idx) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_addr_nxt  = 8'd0;
                    w_state_nxt = ST_L_PULL;
                end
            end
            ST_L_PULL: if (si_valid) begin
                w_wdat_nxt   = si_dat;
                w_strb_start = 1'b1;
                w_state_nxt  = ST_L_WRITE;
            end
            ST_L_WRITE: if (w_strb_done) begin
                if (r_addr == c_last_addr) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_addr_nxt  = r_addr + 8'd1;
                    w_state_nxt = ST_L_PULL;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_wcnt     <= '0;
            r_hdr      <= 1'b0;
            r_idx      <= '0;
            r_so_dat   <= '0;
            r_wdat     <= '0;
            r_err      <= 1'b0;
            r_act      <= 1'b0;
            r_done     <= 1'b0;
            r_so_valid <= 1'b0;
            r_si_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_hdr      <= w_hdr_nxt;
            r_idx      <= w_idx_nxt;
            r_so_dat   <= w_so_dat_nxt;
            r_wdat     <= w_wdat_nxt;
            r_err      <= w_err_nxt;
            r_act      <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
            r_done     <= (w_state_nxt == ST_DONE);
            r_so_valid <= (w_state_nxt == ST_S_PUSH);
            r_si_ready <= (w_state_nxt == ST_L_HDR) || (w_state_nxt == ST_L_PULL);
        end
    end

    map_ss_strobe #(
        .WR_SETUP (WR_SETUP),
        .WR_PULSE (WR_PULSE)
    ) u_strobe (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .i_start   (w_strb_start),
        .o_done    (w_strb_done),
        .o_ss_we   (w_we),
        .o_ss_m2   (w_m2)
    );

    always_ff @(posedge clk) begin
        assert (RD_WAIT >= 1 && RD_WAIT <= 15 && WR_SETUP >= 1 && WR_SETUP <= 15
                && WR_PULSE >= 1 && WR_PULSE <= 15)
            else $error("map_ss_engine: wait parameter outside 1..15");
        assert (REG_CNT >= 1 && IDX_ADDR <= 255 && stream_len(REG_CNT) <= IDX_ADDR + 1)
            else $error("map_ss_engine: REG_CNT overlaps IDX_ADDR");
    end

    assign busy       = r_act;
    assign done       = r_done;
    assign err        = r_err;
    assign so_dat     = r_so_dat;
    assign so_valid   = r_so_valid;
    assign si_ready   = r_si_ready;
    assign ss.ss_act  = r_act;
    assign ss.ss_we   = w_we;
    assign ss.ss_m2   = w_m2;
    assign ss.ss_addr = r_addr;
    assign ss.ss_wdat = r_wdat;
endmodule
`default_nettype wire
